// File: rtl/minibus_arbiter.sv
// Round-robin arbiter sharing one minibus master port between N_MASTERS requesters.
// The winning request is latched while BUSY; a per-transaction timeout forces an error completion.
module minibus_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 256
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic [N_MASTERS-1:0]            m_req,
  input  logic [N_MASTERS-1:0]            m_wen,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb,
  output logic [N_MASTERS-1:0]            m_ready,
  output logic [N_MASTERS-1:0]            m_error,
  output logic [DATA_W-1:0]               m_rdata,
  output logic                            bus_req,
  output logic                            bus_wen,
  output logic [ADDR_W-1:0]               bus_addr,
  output logic [DATA_W-1:0]               bus_wdata,
  output logic [DATA_W/8-1:0]             bus_wstrb,
  input  logic                            bus_ready,
  input  logic [DATA_W-1:0]               bus_rdata,
  input  logic                            bus_error,
  output logic [$clog2(N_MASTERS)-1:0]    grant_id,
  output logic                            busy
);

  localparam int GW    = $clog2(N_MASTERS);
  localparam int SW    = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q, state_d;
  logic [GW-1:0]     rr_q, rr_d, grant_q, grant_d, win;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SW-1:0]     wstrb_q, wstrb_d;
  logic              found, timeout_hit, done;
  int                idx;

  // First requester at or above rr_q, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N_MASTERS; k++) begin
      idx = (int'(rr_q) + k) % N_MASTERS;
      if (!found && m_req[idx]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign done        = (state_q == BUSY) && (bus_ready || timeout_hit);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = BUSY;
        grant_d = win;
        cnt_d   = '0;
        wen_d   = m_wen[win];
        addr_d  = m_addr[int'(win)*ADDR_W +: ADDR_W];
        wdata_d = m_wdata[int'(win)*DATA_W +: DATA_W];
        wstrb_d = m_wstrb[int'(win)*SW +: SW];
      end
      BUSY: if (done) begin
        state_d = IDLE;
        rr_d    = (grant_q == GW'(N_MASTERS - 1)) ? '0 : grant_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  // A forced timeout completion reports an error with zero read data.
  for (genvar i = 0; i < N_MASTERS; i++) begin : g_resp
    assign m_ready[i] = done && (grant_q == GW'(i));
    assign m_error[i] = m_ready[i] && (!bus_ready || bus_error);
  end

  assign m_rdata   = (done && bus_ready) ? bus_rdata : '0;
  assign busy      = (state_q == BUSY);
  assign bus_req   = busy;
  assign bus_wen   = wen_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_wstrb = wstrb_q;
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_minibus_arbiter.sv
// Bench for minibus_arbiter: A is 3 masters with TIMEOUT=4, B is 2 masters with the timeout disabled.
module tb_minibus_arbiter;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  localparam int TO_A = 4;

  // DUT A: 3 masters, TIMEOUT=4
  logic [2:0]  a_req = '0, a_wen = '0;
  logic [95:0] a_addr = '0, a_wdata = '0;
  logic [11:0] a_wstrb = '0;
  logic [2:0]  a_m_ready, a_m_error;
  logic [31:0] a_m_rdata, a_bus_addr, a_bus_wdata;
  logic        a_bus_req, a_bus_wen, a_busy;
  logic [3:0]  a_bus_wstrb;
  logic        a_bus_ready = 1'b0, a_bus_error = 1'b0;
  logic [31:0] a_bus_rdata = '0;
  logic [1:0]  a_grant_id;

  // DUT B: 2 masters, timeout disabled
  logic [1:0]  b_req = '0, b_wen = '0;
  logic [63:0] b_addr = '0, b_wdata = '0;
  logic [7:0]  b_wstrb = '0;
  logic [1:0]  b_m_ready, b_m_error;
  logic [31:0] b_m_rdata, b_bus_addr, b_bus_wdata;
  logic        b_bus_req, b_bus_wen, b_busy;
  logic [3:0]  b_bus_wstrb;
  logic        b_bus_ready = 1'b0, b_bus_error = 1'b0;
  logic [31:0] b_bus_rdata = '0;
  logic [0:0]  b_grant_id;

  minibus_arbiter #(.N_MASTERS(3), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO_A)) u_a (
    .clk(clk), .nrst(nrst), .m_req(a_req), .m_wen(a_wen), .m_addr(a_addr),
    .m_wdata(a_wdata), .m_wstrb(a_wstrb), .m_ready(a_m_ready), .m_error(a_m_error),
    .m_rdata(a_m_rdata), .bus_req(a_bus_req), .bus_wen(a_bus_wen), .bus_addr(a_bus_addr),
    .bus_wdata(a_bus_wdata), .bus_wstrb(a_bus_wstrb), .bus_ready(a_bus_ready),
    .bus_rdata(a_bus_rdata), .bus_error(a_bus_error), .grant_id(a_grant_id), .busy(a_busy));

  minibus_arbiter #(.N_MASTERS(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) u_b (
    .clk(clk), .nrst(nrst), .m_req(b_req), .m_wen(b_wen), .m_addr(b_addr),
    .m_wdata(b_wdata), .m_wstrb(b_wstrb), .m_ready(b_m_ready), .m_error(b_m_error),
    .m_rdata(b_m_rdata), .bus_req(b_bus_req), .bus_wen(b_bus_wen), .bus_addr(b_bus_addr),
    .bus_wdata(b_bus_wdata), .bus_wstrb(b_bus_wstrb), .bus_ready(b_bus_ready),
    .bus_rdata(b_bus_rdata), .bus_error(b_bus_error), .grant_id(b_grant_id), .busy(b_busy));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, " a_bus_req"}, a_bus_req, 0);
    chk({tag, " a_busy"}, a_busy, 0);
    chk({tag, " a_m_ready"}, a_m_ready, 0);
    chk({tag, " a_m_error"}, a_m_error, 0);
    chk({tag, " a_m_rdata"}, a_m_rdata, 0);
    chk({tag, " a_bus_addr"}, a_bus_addr, 0);
    chk({tag, " a_bus_wdata"}, a_bus_wdata, 0);
    chk({tag, " a_bus_wstrb"}, a_bus_wstrb, 0);
    chk({tag, " a_bus_wen"}, a_bus_wen, 0);
    chk({tag, " a_grant_id"}, a_grant_id, 0);
  endtask

  // Directed vectors for B; master 0 address is fixed at 0x1000, master 1 writes 0x55AA/0xF.
  typedef struct {
    logic [1:0]  req;
    logic [1:0]  wen;
    logic [31:0] addr1;
    logic        rdy;
    logic        berr;
    logic [31:0] rdata;
    logic        e_breq;
    logic [31:0] e_addr;
    logic        e_wen;
    logic [31:0] e_wdata;
    logic [1:0]  e_rdy;
    logic [1:0]  e_err;
    logic [31:0] e_rdata;
    logic        e_gid;
  } vec_t;
  vec_t tbl[10];

  // Transaction-level reference for A
  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;
  bit   mb_busy;
  int   m_grant, m_rr, m_cnt;
  txn_t m_lat;

  task automatic model_reset();
    mb_busy = 0; m_grant = 0; m_rr = 0; m_cnt = 0;
    m_lat = '{wen: 1'b0, addr: 32'h0, wdata: 32'h0, wstrb: 4'h0};
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [2:0]  e_rdy3, e_err3;
    logic [31:0] e_rd;
    bit          done;

    tbl[0] = '{2'b00, 2'b00, 32'h20, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 32'h0,    2'b00, 2'b00, 32'h0,        1'b0};
    tbl[1] = '{2'b01, 2'b00, 32'h20, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 32'h0,    2'b00, 2'b00, 32'h0,        1'b0};
    tbl[2] = '{2'b01, 2'b00, 32'h20, 1'b0, 1'b0, 32'h0,        1'b1, 32'h1000, 1'b0, 32'h0,    2'b00, 2'b00, 32'h0,        1'b0};
    tbl[3] = '{2'b01, 2'b00, 32'h20, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 32'h1000, 1'b0, 32'h0,    2'b01, 2'b00, 32'hDEADBEEF, 1'b0};
    tbl[4] = '{2'b00, 2'b00, 32'h20, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h1000, 1'b0, 32'h0,    2'b00, 2'b00, 32'h0,        1'b0};
    tbl[5] = '{2'b10, 2'b10, 32'h20, 1'b0, 1'b0, 32'h0,        1'b0, 32'h1000, 1'b0, 32'h0,    2'b00, 2'b00, 32'h0,        1'b0};
    tbl[6] = '{2'b10, 2'b10, 32'h99, 1'b0, 1'b0, 32'h0,        1'b1, 32'h20,   1'b1, 32'h55AA, 2'b00, 2'b00, 32'h0,        1'b1};
    tbl[7] = '{2'b10, 2'b10, 32'h99, 1'b0, 1'b0, 32'h0,        1'b1, 32'h20,   1'b1, 32'h55AA, 2'b00, 2'b00, 32'h0,        1'b1};
    tbl[8] = '{2'b10, 2'b10, 32'h99, 1'b1, 1'b1, 32'h1234,     1'b1, 32'h20,   1'b1, 32'h55AA, 2'b10, 2'b10, 32'h1234,     1'b1};
    tbl[9] = '{2'b00, 2'b00, 32'h99, 1'b0, 1'b0, 32'h0,        1'b0, 32'h20,   1'b1, 32'h55AA, 2'b00, 2'b00, 32'h0,        1'b1};

    b_wdata = {32'h55AA, 32'h0};
    b_wstrb = {4'hF, 4'h0};

    // Reset state
    #1;
    chk_a_zero("reset");
    chk("reset b_bus_req", b_bus_req, 0);
    chk("reset b_m_ready", b_m_ready, 0);
    chk("reset b_busy", b_busy, 0);
    @(negedge clk);
    nrst = 1'b1;

    // Table-driven: basic read and held-address write with slave error on B
    for (int r = 0; r < 10; r++) begin
      @(negedge clk);
      b_req = tbl[r].req; b_wen = tbl[r].wen; b_addr = {tbl[r].addr1, 32'h1000};
      b_bus_ready = tbl[r].rdy; b_bus_error = tbl[r].berr; b_bus_rdata = tbl[r].rdata;
      #1;
      chk($sformatf("row%0d bus_req", r), b_bus_req, tbl[r].e_breq);
      chk($sformatf("row%0d bus_addr", r), b_bus_addr, tbl[r].e_addr);
      chk($sformatf("row%0d bus_wen", r), b_bus_wen, tbl[r].e_wen);
      chk($sformatf("row%0d bus_wdata", r), b_bus_wdata, tbl[r].e_wdata);
      chk($sformatf("row%0d m_ready", r), b_m_ready, tbl[r].e_rdy);
      chk($sformatf("row%0d m_error", r), b_m_error, tbl[r].e_err);
      chk($sformatf("row%0d m_rdata", r), b_m_rdata, tbl[r].e_rdata);
      chk($sformatf("row%0d grant_id", r), b_grant_id, tbl[r].e_gid);
    end

    // B: 1000-cycle stall, no forced completion without a timeout
    @(negedge clk);
    b_req = 2'b01; b_wen = 2'b00; b_bus_ready = 1'b0; b_bus_error = 1'b0;
    #1 chk("stall idle bus_req", b_bus_req, 0);
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk); #1;
      chk("stall bus_req", b_bus_req, 1);
      chk("stall m_ready", b_m_ready, 0);
    end
    @(negedge clk);
    b_bus_ready = 1'b1; b_bus_rdata = 32'h600DF00D;
    #1;
    chk("stall end m_ready", b_m_ready, 2'b01);
    chk("stall end m_rdata", b_m_rdata, 32'h600DF00D);
    @(negedge clk);
    b_req = 2'b00; b_bus_ready = 1'b0;

    // A: round robin with all requests held, slave ready on the 2nd BUSY cycle
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      a_req = 3'b111; a_bus_ready = (c % 3 == 2); a_bus_error = 1'b0;
      #1;
      chk($sformatf("rr c%0d bus_req", c), a_bus_req, (c % 3) != 0);
      chk($sformatf("rr c%0d m_ready", c), a_m_ready, (c % 3 == 2) ? 3'(1 << ((c / 3) % 3)) : 3'b000);
      if (c % 3 != 0) chk($sformatf("rr c%0d grant_id", c), a_grant_id, (c / 3) % 3);
    end

    // A: timeout after 4 BUSY cycles, then next requester granted
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      a_req = (c <= 4) ? 3'b001 : 3'b010;
      a_bus_ready = (c == 6); a_bus_rdata = 32'hCAFE0000;
      #1;
      chk($sformatf("to c%0d bus_req", c), a_bus_req, (c >= 1 && c <= 4) || c == 6);
      chk($sformatf("to c%0d m_ready", c), a_m_ready, (c == 4) ? 3'b001 : (c == 6) ? 3'b010 : 3'b000);
      chk($sformatf("to c%0d m_error", c), a_m_error, (c == 4) ? 3'b001 : 3'b000);
      chk($sformatf("to c%0d m_rdata", c), a_m_rdata, (c == 6) ? 32'hCAFE0000 : 32'h0);
      if (c == 6) chk("to grant_id", a_grant_id, 1);
    end

    // A: async reset in the 2nd BUSY cycle of master 2 restarts the search from 0
    @(negedge clk);
    a_req = 3'b110; a_bus_ready = 1'b0;
    #1 chk("rst idle bus_req", a_bus_req, 0);
    @(negedge clk); #1;
    chk("rst pre grant_id", a_grant_id, 2);
    @(negedge clk); #1;
    chk("rst pre bus_req", a_bus_req, 1);
    nrst = 1'b0;
    #1 chk_a_zero("rst async");
    @(negedge clk);
    nrst = 1'b1;
    #1;
    chk("rst rel bus_req", a_bus_req, 0);
    chk("rst rel m_ready", a_m_ready, 0);
    @(negedge clk); #1;
    chk("rst regrant bus_req", a_bus_req, 1);
    chk("rst regrant grant_id", a_grant_id, 1);
    @(negedge clk);
    a_bus_ready = 1'b1;
    #1 chk("rst regrant m_ready", a_m_ready, 3'b010);
    @(negedge clk);
    a_req = 3'b000; a_bus_ready = 1'b0;
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    model_reset();

    // A: random stimulus against the reference
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      a_req = 3'($urandom_range(0, 7)); a_wen = 3'($urandom_range(0, 7));
      a_addr = {$urandom, $urandom, $urandom}; a_wdata = {$urandom, $urandom, $urandom};
      a_wstrb = 12'($urandom); a_bus_ready = ($urandom_range(0, 3) == 0);
      a_bus_error = 1'($urandom); a_bus_rdata = $urandom;
      #1;
      done   = mb_busy && (a_bus_ready || m_cnt == TO_A - 1);
      e_rdy3 = done ? 3'(1 << m_grant) : 3'b000;
      e_err3 = (done && (!a_bus_ready || a_bus_error)) ? e_rdy3 : 3'b000;
      e_rd   = (done && a_bus_ready) ? a_bus_rdata : 32'h0;
      chk("rnd bus_req", a_bus_req, mb_busy);
      chk("rnd busy", a_busy, mb_busy);
      chk("rnd grant_id", a_grant_id, m_grant);
      chk("rnd m_ready", a_m_ready, e_rdy3);
      chk("rnd m_error", a_m_error, e_err3);
      chk("rnd m_rdata", a_m_rdata, e_rd);
      chk("rnd bus_addr", a_bus_addr, m_lat.addr);
      chk("rnd bus_wdata", a_bus_wdata, m_lat.wdata);
      chk("rnd bus_wstrb", a_bus_wstrb, m_lat.wstrb);
      chk("rnd bus_wen", a_bus_wen, m_lat.wen);
      // advance the reference to the state after the coming edge
      if (!mb_busy) begin
        for (int k = 0; k < 3; k++) begin
          int i;
          i = (m_rr + k) % 3;
          if (!mb_busy && a_req[i]) begin
            mb_busy = 1; m_grant = i; m_cnt = 0;
            m_lat = '{wen: a_wen[i], addr: a_addr[i*32 +: 32],
                      wdata: a_wdata[i*32 +: 32], wstrb: a_wstrb[i*4 +: 4]};
          end
        end
      end else if (done) begin
        mb_busy = 0;
        m_rr = (m_grant + 1) % 3;
      end else begin
        m_cnt++;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/minibus_arbiter.md
Name: minibus_arbiter

Overview:
- Shares the single minibus master port in front of the minibus address decoder between N_MASTERS requesters, e.g. CPU fetch, CPU load/store and a debug port.
- Arbitration is round-robin. The granted request is latched and held stable until the bus completes it.
- A per-transaction timeout counter guarantees forward progress when an unmapped or hung slave never responds.

Parameters:
- N_MASTERS, 2, number of requesting masters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width (multiple of 8).
- TIMEOUT, 256, max cycles in BUSY before forced error completion; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- m_req  in  N_MASTERS  per-master request valid.
- m_wen  in  N_MASTERS  per-master write enable (0 = read).
- m_addr  in  N_MASTERS*ADDR_W  packed addresses; master i occupies bits [i*ADDR_W +: ADDR_W].
- m_wdata  in  N_MASTERS*DATA_W  packed write data.
- m_wstrb  in  N_MASTERS*DATA_W/8  packed byte strobes.
- m_ready  out  N_MASTERS  one-hot completion pulse to the granted master.
- m_error  out  N_MASTERS  error flag, valid only with m_ready.
- m_rdata  out  DATA_W  read data, broadcast to all masters, valid with m_ready.
- bus_req  out  1  request to the decoder.
- bus_wen  out  1  latched write enable.
- bus_addr  out  ADDR_W  latched address.
- bus_wdata  out  DATA_W  latched write data.
- bus_wstrb  out  DATA_W/8  latched strobes.
- bus_ready  in  1  completion from the decoder/slave.
- bus_rdata  in  DATA_W  read data from the decoder/slave.
- bus_error  in  1  slave error.
- grant_id  out  $clog2(N_MASTERS)  index of the current or last granted master.
- busy  out  1  high while in BUSY.

Behaviour:
- Reset (async, nrst=0):
  - state=IDLE, rr_ptr=0, grant_id=0, timeout counter=0.
  - All bus_* outputs, m_ready, m_error and m_rdata are 0; busy=0.
  - Reset mid-transaction abandons the transaction silently; no m_ready is issued.
- States: IDLE and BUSY.
- IDLE:
  - bus_req=0.
  - If any m_req is set, the winner is the first set bit searching upward from rr_ptr, wrapping from N_MASTERS-1 to 0.
  - On the next edge: grant_id=winner; wen, addr, wdata and wstrb of the winner are registered into bus_*; counter cleared; state goes to BUSY.
- BUSY:
  - bus_req=1 and busy=1. bus_* fields are held constant regardless of m_* changes.
  - Completion when bus_ready=1 (combinational, same cycle):
    - m_ready[grant_id]=1, m_error[grant_id]=bus_error, m_rdata=bus_rdata.
    - Next edge: state goes to IDLE, rr_ptr=(grant_id+1) mod N_MASTERS.
  - Timeout:
    - Counter increments each BUSY cycle without bus_ready.
    - If TIMEOUT != 0 and the counter equals TIMEOUT-1 with bus_ready=0: m_ready[grant_id]=1, m_error[grant_id]=1, m_rdata=0.
    - Next edge: IDLE, same rr_ptr update as normal completion.
    - bus_ready arriving in the timeout cycle takes priority as a normal completion.
- Latency:
  - m_req seen in cycle 0 gives bus_req in cycle 1; earliest m_ready is cycle 1.
  - There is one mandatory IDLE cycle between back-to-back transactions.
- Outside a completion cycle, m_ready, m_error and m_rdata are all 0.
- Master rules:
  - A master keeps m_req high until its m_ready.
  - m_req still high in the cycle after m_ready is a new request.
  - Dropping m_req while granted does not cancel the transaction; m_ready is still pulsed.
- Only one m_ready bit may ever be set.
- grant_id holds its value in IDLE.

Test Plan:
- Reset with no requests -> all outputs 0, busy=0; after m_req[0]=1 (read, addr 0x1000), bus_req=1 with bus_addr=0x1000 one cycle later. bus_ready with bus_rdata=0xDEADBEEF -> m_ready=2'b01, m_rdata=0xDEADBEEF in the same cycle.
- Round-robin with N_MASTERS=3, all m_req held high, slave ready after 2 cycles -> grant order 0,1,2,0,1,2 with one IDLE cycle between grants.
- Master 1 writes 0x55AA to addr 0x20 with wstrb=0xF, then changes m_addr to 0x99 while BUSY -> bus_addr stays 0x20 until bus_ready. On bus_ready with bus_error=1 -> m_ready[1]=1, m_error[1]=1.
- TIMEOUT=4, slave never ready -> bus_req high exactly 4 cycles, then m_ready[g]=1, m_error[g]=1, m_rdata=0; arbiter returns to IDLE and grants the next requester.
- nrst pulsed low in the 2nd BUSY cycle -> outputs clear immediately (asynchronously), no m_ready; after release the pending m_req[1] is granted with rr_ptr=0 search order.
- TIMEOUT=0 with a 1000-cycle stall -> no forced completion; bus_req stays high until bus_ready.
